// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port flip-flop register file.
//   clr_state_e  : state encoding of the clear-sweep FSM
//   be_to_mask() : expands a byte-enable vector into a per-bit write mask
package register_file_pkg;

    typedef enum logic {
        ClrIdle  = 1'b0,
        ClrSweep = 1'b1
    } clr_state_e;

    // The helper works on the widest supported word; callers zero-extend
    // their byte enables and keep the low DataWidth bits of the result.
    localparam int unsigned MaxBeWidth   = 32;
    localparam int unsigned MaxDataWidth = MaxBeWidth * 8;

    function automatic logic [MaxDataWidth-1:0] be_to_mask(
        input logic [MaxBeWidth-1:0] be
    );
        logic [MaxDataWidth-1:0] mask;
        mask = '0;
        for (int b = 0; b < MaxBeWidth; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/register_file_clear_ctrl.sv
// Clear-sweep controller: walks a pointer over every word, one per cycle.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : sweep request, only looked at while idle
//   busy_o        : high for exactly 2**AddrWidth cycles of an active sweep
//   clr_en        : zero mem[clr_addr] at this edge
//   clr_addr      : word being cleared this cycle
//   state_o       : current FSM state, exported for observation
//
// Handshake: clear_i is a request that is accepted at any edge where
// busy_o is low; busy_o rises on the following cycle and stays high until
// the last word has been cleared. Requests while busy_o is high are ignored,
// there is no queueing.
module register_file_clear_ctrl
    import register_file_pkg::*;
#(
    parameter int unsigned AddrWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic                 clr_en,
    output logic [AddrWidth-1:0] clr_addr,
    output clr_state_e           state_o
);

    localparam logic [AddrWidth-1:0] LastAddr = '1;

    clr_state_e           state_q, state_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ClrIdle: begin
                if (clear_i) begin
                    state_d = ClrSweep;
                    ptr_d   = '0;
                end
            end
            ClrSweep: begin
                // The wrap after the last word is the end of the sweep.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LastAddr) begin
                    state_d = ClrIdle;
                end
            end
            default: begin
                state_d = ClrIdle;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ClrIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o   = (state_q == ClrSweep);
    assign clr_en   = (state_q == ClrSweep);
    assign clr_addr = ptr_q;
    assign state_o  = state_q;

endmodule

// File: rtl/register_file_mp_ff.sv
// Multi-port flip-flop register file with byte-enable writes, write-first
// forwarding, an optional hard-wired zero word and a clear sweep.
//   clk_i, rst_ni       : clock, synchronous active-low reset
//   clear_i / busy_o    : clear request / sweep in progress
//   re_i, raddr_i       : per-port read enable and address
//   rdata_o, rvalid_o   : per-port registered read data and valid (latency 1)
//   we_i, waddr_i,
//   wdata_i, wbe_i      : write port with per-byte enables
module register_file_mp_ff
    import register_file_pkg::*;
#(
    parameter int unsigned AddrWidth    = 4,
    parameter int unsigned DataWidth    = 16,
    parameter int unsigned NumReadPorts = 2,
    parameter bit          ZeroWord0    = 1'b1,
    localparam int unsigned BeWidth     = DataWidth / 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    clear_i,
    output logic                                    busy_o,
    input  logic [NumReadPorts-1:0]                 re_i,
    input  logic [NumReadPorts-1:0][AddrWidth-1:0]  raddr_i,
    output logic [NumReadPorts-1:0][DataWidth-1:0]  rdata_o,
    output logic [NumReadPorts-1:0]                 rvalid_o,
    input  logic                                    we_i,
    input  logic [AddrWidth-1:0]                    waddr_i,
    input  logic [DataWidth-1:0]                    wdata_i,
    input  logic [BeWidth-1:0]                      wbe_i
);

    localparam int unsigned NumWords = 2 ** AddrWidth;

    if ((DataWidth % 8) != 0 || DataWidth == 0) begin : g_bad_width
        $error("DataWidth must be a non-zero multiple of 8");
    end
    if (BeWidth > MaxBeWidth) begin : g_too_wide
        $error("DataWidth exceeds the widest supported word");
    end
    if (NumReadPorts < 1) begin : g_no_ports
        $error("NumReadPorts must be at least 1");
    end

    logic                 busy;
    logic                 clr_en;
    logic [AddrWidth-1:0] clr_addr;
    clr_state_e           clr_state;

    register_file_clear_ctrl #(
        .AddrWidth (AddrWidth)
    ) u_clear_ctrl (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .busy_o   (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .state_o  (clr_state)
    );

    logic [NumWords-1:0][DataWidth-1:0]     mem_q, mem_d;
    logic [NumReadPorts-1:0][DataWidth-1:0] rdata_q, rdata_d;
    logic [NumReadPorts-1:0]                rvalid_q, rvalid_d;

    logic [MaxBeWidth-1:0]   be_ext;
    logic [MaxDataWidth-1:0] wmask_full;
    logic [DataWidth-1:0]    wmask;
    logic [DataWidth-1:0]    wr_merged;
    logic                    wr_accept;
    logic                    rd_blank;

    // Write merge: the merged word is both the new storage value and the
    // forwarded read value, so same-cycle readers see write-first data.
    always_comb begin
        be_ext = '0;
        be_ext[BeWidth-1:0] = wbe_i;
        wmask_full = be_to_mask(be_ext);
        wmask      = wmask_full[DataWidth-1:0];
        wr_accept  = we_i && !busy && (wbe_i != '0) &&
                     !(ZeroWord0 && (waddr_i == '0));
        wr_merged  = (mem_q[waddr_i] & ~wmask) | (wdata_i & wmask);

        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end else if (wr_accept) begin
            mem_d[waddr_i] = wr_merged;
        end
    end

    // Reads stay accepted during a sweep but return zero: the array is
    // half-cleared at that point and no word is meaningful.
    always_comb begin
        rd_blank = (clr_state == ClrSweep);
        rdata_d  = rdata_q;
        rvalid_d = re_i;
        for (int p = 0; p < NumReadPorts; p++) begin
            if (re_i[p]) begin
                if (rd_blank) begin
                    rdata_d[p] = '0;
                end else if (ZeroWord0 && (raddr_i[p] == '0)) begin
                    rdata_d[p] = '0;
                end else if (wr_accept && (raddr_i[p] == waddr_i)) begin
                    rdata_d[p] = wr_merged;
                end else begin
                    rdata_d[p] = mem_q[raddr_i[p]];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign busy_o   = busy;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_register_file_mp_ff.sv
// Bench for register_file_mp_ff with default parameters (16 x 16, 2 ports,
// zero word enabled). A word-level reference model tracks memory contents
// and the remaining length of a clear sweep.
module tb_register_file_mp_ff;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             busy_o;
    logic [1:0]       re;
    logic [1:0][3:0]  raddr;
    logic [1:0][15:0] rdata_o;
    logic [1:0]       rvalid_o;
    logic             we;
    logic [3:0]       waddr;
    logic [15:0]      wdata;
    logic [1:0]       wbe;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    logic [15:0]      m_mem [16];
    int               m_busy_left = 0;
    logic [1:0][15:0] exp_rdata = '0;
    logic [1:0]       exp_rvalid = '0;
    logic             exp_busy = 1'b0;

    always #5 clk = ~clk;

    register_file_mp_ff dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear),
        .busy_o   (busy_o),
        .re_i     (re),
        .raddr_i  (raddr),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .wbe_i    (wbe)
    );

    task automatic idle_inputs();
        clear = 1'b0;
        re    = 2'b00;
        raddr = '0;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        wbe   = '0;
    endtask

    // Computes the expected outcome of the current inputs, applies one clock
    // edge and leaves time 1 unit past the edge for sampling.
    task automatic step();
        logic [15:0] merged;
        bit          acc;
        bit          sweeping;
        sweeping = (m_busy_left > 0);
        acc      = we && !sweeping && (wbe != 2'b00) && (waddr != 4'd0);
        merged   = m_mem[waddr];
        for (int b = 0; b < 2; b++) begin
            if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        for (int p = 0; p < 2; p++) begin
            exp_rvalid[p] = re[p];
            if (re[p]) begin
                if (sweeping || raddr[p] == 4'd0) exp_rdata[p] = 16'h0000;
                else if (acc && raddr[p] == waddr) exp_rdata[p] = merged;
                else exp_rdata[p] = m_mem[raddr[p]];
            end
        end
        if (!rst_n) begin
            for (int a = 0; a < 16; a++) m_mem[a] = 16'h0000;
            exp_rdata   = '0;
            exp_rvalid  = '0;
            m_busy_left = 0;
        end else begin
            if (acc) m_mem[waddr] = merged;
            if (sweeping) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    for (int a = 0; a < 16; a++) m_mem[a] = 16'h0000;
                end
            end else if (clear) begin
                m_busy_left = 16;
            end
        end
        exp_busy = (m_busy_left > 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all();
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            we    = 1'b1;
            waddr = 4'(a);
            wdata = 16'($urandom_range(16'hFFFF, 1));
            wbe   = 2'b11;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if (busy_o !== 1'b0 || rvalid_o !== 2'b00 || rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state busy=%b rvalid=%b rdata=%h want 0/00/0", busy_o, rvalid_o, rdata_o);
        end
        rst_n = 1'b1;
        re = 2'b11; raddr[0] = 4'd3; raddr[1] = 4'd7;
        step();
        vectors++;
        if (rvalid_o !== 2'b11 || rdata_o !== {16'h0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_read rvalid=%b rdata=%h want 11/00000000", rvalid_o, rdata_o);
        end
        idle_inputs();
        step();
        vectors++;
        if (rvalid_o !== 2'b00 || rdata_o !== exp_rdata) begin
            miscompares++;
            $display("FAIL reset_read_hold rvalid=%b rdata=%h want 00/%h", rvalid_o, rdata_o, exp_rdata);
        end
    endtask

    task automatic test_byte_enable();
        idle_inputs();
        we = 1'b1; waddr = 4'd5; wdata = 16'hABCD; wbe = 2'b11;
        step();
        wdata = 16'h1234; wbe = 2'b01;
        step();
        wbe = 2'b00; wdata = 16'hFFFF;
        step();
        idle_inputs();
        re = 2'b01; raddr[0] = 4'd5;
        step();
        vectors++;
        if (rvalid_o[0] !== 1'b1 || rdata_o[0] !== 16'hAB34 || rdata_o !== exp_rdata) begin
            miscompares++;
            $display("FAIL byte_enable rvalid=%b rdata0=%h want 1/ab34", rvalid_o[0], rdata_o[0]);
        end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        we = 1'b1; waddr = 4'd9; wdata = 16'h00FF; wbe = 2'b11;
        step();
        wdata = 16'h5500; wbe = 2'b10;
        re = 2'b11; raddr[0] = 4'd9; raddr[1] = 4'd9;
        step();
        vectors++;
        if (rvalid_o !== 2'b11 || rdata_o !== {16'h55FF, 16'h55FF} || rdata_o !== exp_rdata) begin
            miscompares++;
            $display("FAIL forward_same_cycle rvalid=%b rdata=%h want 11/55ff55ff", rvalid_o, rdata_o);
        end
        idle_inputs();
        re = 2'b10; raddr[1] = 4'd9;
        step();
        vectors++;
        if (rdata_o[1] !== 16'h55FF || rvalid_o !== 2'b10) begin
            miscompares++;
            $display("FAIL forward_later_read rvalid=%b rdata1=%h want 10/55ff", rvalid_o, rdata_o[1]);
        end
    endtask

    task automatic test_zero_word();
        idle_inputs();
        we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; wbe = 2'b11;
        re = 2'b11; raddr[0] = 4'd0; raddr[1] = 4'd0;
        step();
        vectors++;
        if (rdata_o !== 32'h0 || rvalid_o !== 2'b11) begin
            miscompares++;
            $display("FAIL zero_word_forward rvalid=%b rdata=%h want 11/00000000", rvalid_o, rdata_o);
        end
        idle_inputs();
        re = 2'b01; raddr[0] = 4'd0;
        step();
        vectors++;
        if (rdata_o[0] !== 16'h0000) begin
            miscompares++;
            $display("FAIL zero_word_after rdata0=%h want 0000", rdata_o[0]);
        end
    endtask

    task automatic read_all_zero(input string name);
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            re = 2'b11; raddr[0] = 4'(a); raddr[1] = 4'(15 - a);
            step();
            vectors++;
            if (rvalid_o !== 2'b11 || rdata_o !== 32'h0 || rdata_o !== exp_rdata) begin
                miscompares++;
                $display("FAIL %s addr=%0d rvalid=%b rdata=%h want 11/00000000", name, a, rvalid_o, rdata_o);
            end
        end
        idle_inputs();
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o !== 1'b1) break;
            cnt++;
            idle_inputs();
            if (i == 1) begin
                we = 1'b1; waddr = 4'd2; wdata = 16'h1111; wbe = 2'b11;
                re = 2'b01; raddr[0] = 4'd2;
            end else begin
                re = 2'b10; raddr[1] = 4'($urandom_range(15));
            end
            step();
            vectors++;
            if (rvalid_o !== exp_rvalid || rdata_o !== exp_rdata || busy_o !== exp_busy) begin
                miscompares++;
                $display("FAIL %s_cycle%0d busy=%b rvalid=%b rdata=%h want %b/%b/%h", name, i, busy_o, rvalid_o, rdata_o, exp_busy, exp_rvalid, exp_rdata);
            end
        end
        vectors++;
        if (cnt != 16) begin
            miscompares++;
            $display("FAIL %s_length busy_cycles=%0d want 16", name, cnt);
        end
        idle_inputs();
    endtask

    task automatic test_clear_sweep();
        fill_all();
        clear = 1'b1;
        step();
        clear = 1'b0;
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_start busy=%b want 1", busy_o);
        end
        count_busy("clear_sweep");
        read_all_zero("clear_after");
    endtask

    task automatic test_reset_mid_sweep();
        fill_all();
        clear = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if (busy_o !== 1'b0 || rvalid_o !== 2'b00 || rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_sweep_reset busy=%b rvalid=%b rdata=%h want 0/00/0", busy_o, rvalid_o, rdata_o);
        end
        read_all_zero("mid_sweep_after");
        fill_all();
        clear = 1'b1;
        step();
        clear = 1'b0;
        count_busy("restart_sweep");
    endtask

    // Random traffic, including occasional clear requests and combined
    // clear+write cycles, checked cycle by cycle against the model.
    task automatic test_back_to_back();
        idle_inputs();
        for (int i = 0; i < 300; i++) begin
            we       = 1'($urandom_range(1));
            waddr    = 4'($urandom_range(15));
            wdata    = 16'($urandom_range(16'hFFFF));
            wbe      = 2'($urandom_range(3));
            re       = 2'($urandom_range(3));
            raddr[0] = ($urandom_range(3) == 0) ? waddr : 4'($urandom_range(15));
            raddr[1] = ($urandom_range(3) == 0) ? waddr : 4'($urandom_range(15));
            clear    = ($urandom_range(99) < 2);
            step();
            vectors++;
            if (rvalid_o !== exp_rvalid || rdata_o !== exp_rdata || busy_o !== exp_busy) begin
                miscompares++;
                $display("FAIL random_%0d busy=%b rvalid=%b rdata=%h want %b/%b/%h", i, busy_o, rvalid_o, rdata_o, exp_busy, exp_rvalid, exp_rdata);
            end
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) step();
    endtask

    initial begin
        for (int a = 0; a < 16; a++) m_mem[a] = 16'h0000;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_byte_enable();
        test_forwarding();
        test_zero_word();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
